bram_dump_reader: RTL
=====================

Name: bram_dump_reader

Overview:
- Read-side counterpart of the data/instruction BRAM write-port initialisation path.
- On `start`, walks a contiguous word range of a bram32 instance through its debug read port (`debug_addr`/`debug_data`).
- Streams each word out on a valid/ready interface, together with its byte address and a last flag.
- Used for post-run memory dumps (self-checking benches, later a UART dump path) without disturbing the CPU-owned read/write ports.

Parameters:
- ADDR_WIDTH, 12, byte-address width of the debug port; address wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32, word width.
- CNT_WIDTH, 11, width of word_count; 1024 words max for the 4 KiB BRAM.
- READ_LATENCY, 1, cycles from debug_addr change to valid debug_data; legal range 0..3.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous assert, active-low; synchronous deassert is the integrator's responsibility.
- start  input  1  1-cycle request; sampled only in IDLE.
- abort  input  1  cancels a dump in progress; takes priority over everything except rst.
- base_addr  input  ADDR_WIDTH  first byte address; bits [1:0] are ignored and treated as 00.
- word_count  input  CNT_WIDTH  number of words to dump.
- debug_addr  output  ADDR_WIDTH  address to the bram32 debug port; registered.
- debug_data  input  DATA_WIDTH  word from the bram32 debug port.
- out_valid  output  1  out_data, out_addr and out_last are valid.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_WIDTH  dumped word.
- out_addr  output  ADDR_WIDTH  byte address of out_data.
- out_last  output  1  high with the final word of the dump.
- busy  output  1  high in every state except IDLE.
- done  output  1  1-cycle pulse when the dump completes normally.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; debug_addr=0, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0; internal counters cleared. A reset mid-dump discards all progress.
- States: IDLE, ISSUE, WAIT, PRESENT, FINISH.
- IDLE:
  - start=1 and word_count!=0 → ISSUE. Latch base_addr&~3 into debug_addr and word_count into the remaining counter.
  - start=1 and word_count==0 → FINISH. No debug read, no output.
  - start is ignored in every other state.
- ISSUE: debug_addr is stable.
  - READ_LATENCY==0 → PRESENT, capturing debug_data at this edge.
  - Otherwise → WAIT with the wait counter = READ_LATENCY-1.
- WAIT: decrement the wait counter; at 0 → PRESENT, capturing debug_data into out_data and debug_addr into out_addr. out_last = (remaining==1).
- PRESENT: out_valid=1. out_data, out_addr and out_last hold stable until out_valid&out_ready at a rising edge. On handshake:
  - remaining==1 → FINISH, out_valid=0.
  - Otherwise: remaining-1, debug_addr+4 (modulo 2^ADDR_WIDTH; 0xFFC wraps to 0x000), → ISSUE, out_valid=0.
- Capture timing (READ_LATENCY≥1): out_data is captured at the edge where the state leaves WAIT for PRESENT, after debug_addr has been stable for READ_LATENCY full cycles.
- FINISH: done=1 for exactly this one cycle, then → IDLE; busy drops in the same transition.
- Latency with READ_LATENCY=1 and out_ready held at 1:
  - start sampled at edge k → out_valid high after edge k+2.
  - One word per READ_LATENCY+2 cycles.
  - done high during the cycle after the last handshake.
- out_valid never deasserts without a handshake, except on abort or rst.
- abort=1 in any non-IDLE state: next edge → IDLE, out_valid=0, busy=0. done is not pulsed and debug_addr holds its value. abort in IDLE has no effect.
- abort together with a handshake in PRESENT: the word counts as accepted, but the dump still goes to IDLE without done.
- A word_count larger than 2^(ADDR_WIDTH-2) wraps addresses around and re-reads from the start; this is permitted, not flagged.

Test Plan:
- Basic dump: BRAM preloaded with 00000001, 00000002, 00000003, 00000004 at 0x0..0xC; base_addr=0, word_count=4, out_ready=1. Expect 4 handshakes:
  - out_addr 0x000, 0x004, 0x008, 0x00C;
  - out_data 1, 2, 3, 4;
  - out_last only on the 4th;
  - done one cycle after, then busy=0.
- Backpressure: same data, out_ready toggled 1-0-0-1. out_valid/out_data/out_addr must stay stable while ready=0; the exact same 4-word sequence results; no word is duplicated or dropped.
- Unaligned and wrap: base_addr=0xFFE, word_count=2. Expect out_addr 0xFFC then 0x000; data taken from those words; out_last on the second.
- Zero count: word_count=0, start. Expect busy for exactly one cycle, done pulse, out_valid never asserted, debug_addr unchanged from reset value 0.
- Abort and reset: abort asserted during the 2nd word of a 4-word dump → IDLE next edge, no done, out_valid=0. Separately, rst=0 asynchronously mid-WAIT → all outputs 0 immediately, without waiting for a clock edge.
- Latency sweep: READ_LATENCY=0 and 3 with a BRAM model of matching latency. Expect correct data, with start-to-first-valid of 1 and 4 cycles respectively.

Source files
------------

// File: rtl/bram_dump_reader.sv
// Walks a word range of a bram32 debug read port and streams each word out
// on a valid/ready interface with its byte address and a last flag.
module bram_dump_reader #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH    = 11,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic [ADDR_WIDTH-1:0] debug_addr,
  input  logic [DATA_WIDTH-1:0] debug_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] PRESENT = 3'd3;
  localparam logic [2:0] FINISH  = 3'd4;

  logic [2:0]            state, state_nxt;
  logic [CNT_WIDTH-1:0]  remaining, remaining_nxt;
  logic [1:0]            wait_cnt, wait_cnt_nxt;
  logic [ADDR_WIDTH-1:0] debug_addr_nxt, out_addr_nxt;
  logic [DATA_WIDTH-1:0] out_data_nxt;
  logic                  out_valid_nxt, out_last_nxt, busy_nxt, done_nxt;
  logic                  capture;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      remaining  <= '0;
      wait_cnt   <= '0;
      debug_addr <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      remaining  <= remaining_nxt;
      wait_cnt   <= wait_cnt_nxt;
      debug_addr <= debug_addr_nxt;
      out_valid  <= out_valid_nxt;
      out_data   <= out_data_nxt;
      out_addr   <= out_addr_nxt;
      out_last   <= out_last_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    remaining_nxt  = remaining;
    wait_cnt_nxt   = wait_cnt;
    debug_addr_nxt = debug_addr;
    out_valid_nxt  = out_valid;
    out_data_nxt   = out_data;
    out_addr_nxt   = out_addr;
    out_last_nxt   = out_last;
    capture        = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            state_nxt      = ISSUE;
            debug_addr_nxt = {base_addr[ADDR_WIDTH-1:2], 2'b00};
            remaining_nxt  = word_count;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      ISSUE: begin
        if (READ_LATENCY == 0) begin
          state_nxt = PRESENT;
          capture   = 1'b1;
        end else begin
          state_nxt    = WAIT;
          wait_cnt_nxt = 2'(READ_LATENCY - 1);
        end
      end
      WAIT: begin
        if (wait_cnt == 2'd0) begin
          state_nxt = PRESENT;
          capture   = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt - 2'd1;
        end
      end
      PRESENT: begin
        if (out_valid && out_ready) begin
          out_valid_nxt = 1'b0;
          if (remaining == CNT_WIDTH'(1)) begin
            state_nxt = FINISH;
          end else begin
            remaining_nxt  = remaining - CNT_WIDTH'(1);
            debug_addr_nxt = debug_addr + ADDR_WIDTH'(4);
            state_nxt      = ISSUE;
          end
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (capture) begin
      out_valid_nxt = 1'b1;
      out_data_nxt  = debug_data;
      out_addr_nxt  = debug_addr;
      out_last_nxt  = (remaining == CNT_WIDTH'(1));
    end

    // Abort wins over any transition above; debug_addr and counters freeze
    if (abort && (state != IDLE)) begin
      state_nxt      = IDLE;
      out_valid_nxt  = 1'b0;
      debug_addr_nxt = debug_addr;
      remaining_nxt  = remaining;
    end

    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == FINISH);
  end

endmodule
